priority_encoder_83: RTL and testbench

Registered 8-to-3 priority encoder: reports the index of the highest-numbered asserted input bit plus a valid flag. It sits in request/interrupt arbitration paths, where a single-cycle-registered encoded index is consumed by downstream synchronous logic. Priority is fixed: bit 7 highest, bit 0 lowest.

---
 rtl/prio_enc_pkg.sv | 15 +
 rtl/priority_encoder_83_core.sv | 33 +++
 rtl/priority_encoder_83.sv | 34 +++
 tb/tb_priority_encoder_83.sv | 117 +++++++++++
 4 files changed

// File: rtl/prio_enc_pkg.sv
// prio_enc_pkg: shared widths and highest-set-bit reference function for the priority encoder
package prio_enc_pkg;

    localparam int PE_WIDTH = 8;
    localparam int PE_OUT_W = 3;

    function automatic logic [PE_OUT_W-1:0] pe_highest(input logic [PE_WIDTH-1:0] v);
        logic [PE_OUT_W-1:0] r;
        r = '0;
        for (int i = 0; i < PE_WIDTH; i++)
            if (v[i]) r = PE_OUT_W'(i);
        return r;
    endfunction

endpackage

// File: rtl/priority_encoder_83_core.sv
// priority_encoder_83_core: combinational highest-set-bit encoder built as a log-depth binary tree
module priority_encoder_83_core
    import prio_enc_pkg::*;
#(
    parameter int WIDTH = PE_WIDTH,
    localparam int OUT_W = $clog2(WIDTH)
) (
    input  logic [WIDTH-1:0] in,
    output logic [OUT_W-1:0] out_next,
    output logic             valid_next
);

    for (genvar l = 0; l <= OUT_W; l++) begin : lv
        localparam int N = WIDTH >> l;
        logic [N-1:0] v;
        logic [OUT_W-1:0] x [N];
        if (l == 0) begin : leaf
            assign v = in;
            for (genvar i = 0; i < N; i++) begin : idx
                assign x[i] = OUT_W'(i);
            end
        end else begin : node
            for (genvar i = 0; i < N; i++) begin : mrg
                assign v[i] = lv[l-1].v[2*i+1] | lv[l-1].v[2*i];
                assign x[i] = lv[l-1].v[2*i+1] ? lv[l-1].x[2*i+1] : lv[l-1].x[2*i];
            end
        end
    end

    assign valid_next = lv[OUT_W].v[0];
    assign out_next   = lv[OUT_W].x[0];

endmodule

// File: rtl/priority_encoder_83.sv
// priority_encoder_83: registered 8-to-3 priority encoder, bit 7 highest, with valid flag
module priority_encoder_83
    import prio_enc_pkg::*;
#(
    parameter int WIDTH = PE_WIDTH,
    localparam int OUT_W = $clog2(WIDTH)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [WIDTH-1:0] in,
    output logic [OUT_W-1:0] out,
    output logic             valid
);

    logic [OUT_W-1:0] out_next;
    logic             valid_next;

    priority_encoder_83_core #(.WIDTH(WIDTH)) u_core (
        .in        (in),
        .out_next  (out_next),
        .valid_next(valid_next)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out   <= '0;
            valid <= 1'b0;
        end else begin
            out   <= out_next;
            valid <= valid_next;
        end
    end

endmodule

// File: tb/tb_priority_encoder_83.sv
// tb_priority_encoder_83: directed self-checking bench for the registered priority encoder
module tb_priority_encoder_83;
    import prio_enc_pkg::*;

    logic       clk = 1'b0;
    logic       rst_n = 1'b1;
    logic [7:0] in = 8'h00;
    logic [2:0] out;
    logic       valid;
    int         total = 0;
    int         bad = 0;

    priority_encoder_83 dut (
        .clk  (clk),
        .rst_n(rst_n),
        .in   (in),
        .out  (out),
        .valid(valid)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic step(input string tag, input logic [7:0] v, input logic [2:0] eo, input logic ev);
        in = v;
        @(posedge clk);
        #1;
        chk({tag, ".out"}, {5'd0, out}, {5'd0, eo});
        chk({tag, ".valid"}, {7'd0, valid}, {7'd0, ev});
    endtask

    initial begin
        #400000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        in = 8'hFF;
        #1 rst_n = 1'b0;
        #1;
        chk("rst_async.out", {5'd0, out}, 8'd0);
        chk("rst_async.valid", {7'd0, valid}, 8'd0);
        @(posedge clk);
        @(posedge clk);
        #1;
        chk("rst_hold.out", {5'd0, out}, 8'd0);
        chk("rst_hold.valid", {7'd0, valid}, 8'd0);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        chk("rst_rel.out", {5'd0, out}, 8'd7);
        chk("rst_rel.valid", {7'd0, valid}, 8'd1);

        step("zero", 8'b00000000, 3'd0, 1'b0);
        step("oh0", 8'b00000001, 3'd0, 1'b1);
        step("oh1", 8'b00000010, 3'd1, 1'b1);
        step("oh2", 8'b00000100, 3'd2, 1'b1);
        step("oh3", 8'b00001000, 3'd3, 1'b1);
        step("oh4", 8'b00010000, 3'd4, 1'b1);
        step("oh5", 8'b00100000, 3'd5, 1'b1);
        step("oh6", 8'b01000000, 3'd6, 1'b1);
        step("oh7", 8'b10000000, 3'd7, 1'b1);
        step("m_aa", 8'b10101010, 3'd7, 1'b1);
        step("m_55", 8'b01010101, 3'd6, 1'b1);
        step("m_3c", 8'b00111100, 3'd5, 1'b1);
        step("m_0f", 8'b00001111, 3'd3, 1'b1);
        step("m_ff", 8'b11111111, 3'd7, 1'b1);
        step("m_06", 8'b00000110, 3'd2, 1'b1);
        step("zero2", 8'b00000000, 3'd0, 1'b0);

        step("lat_pre", 8'b00000001, 3'd0, 1'b1);
        in = 8'b10000000;
        #3;
        chk("lat_hold.out", {5'd0, out}, 8'd0);
        chk("lat_hold.valid", {7'd0, valid}, 8'd1);
        @(posedge clk);
        #1;
        chk("lat_upd.out", {5'd0, out}, 8'd7);
        in = 8'b00000000;
        #3;
        chk("lat_hold2.valid", {7'd0, valid}, 8'd1);
        @(posedge clk);
        #1;
        chk("lat_upd2.valid", {7'd0, valid}, 8'd0);

        step("mid_pre", 8'b01000000, 3'd6, 1'b1);
        #2 rst_n = 1'b0;
        #1;
        chk("mid_rst.out", {5'd0, out}, 8'd0);
        chk("mid_rst.valid", {7'd0, valid}, 8'd0);
        rst_n = 1'b1;
        #1;
        chk("mid_gap.out", {5'd0, out}, 8'd0);
        @(posedge clk);
        #1;
        chk("mid_rel.out", {5'd0, out}, 8'd6);
        chk("mid_rel.valid", {7'd0, valid}, 8'd1);

        for (int k = 0; k < 24; k++) begin
            logic [7:0] v;
            v = 8'($urandom);
            step("rnd", v, pe_highest(v), |v);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
